// File: rtl/fdcr_delay_line.sv
// fdcr_delay_line: WIDTH x DEPTH register delay line with async clear, sync reset to SR_VAL,
// clock enable, selectable tap output and saturating fill tracking.
module fdcr_delay_line #(
    parameter int               WIDTH  = 4,
    parameter int               DEPTH  = 4,
    parameter logic [WIDTH-1:0] SR_VAL = '0,
    parameter int               TAP_W  = 2
) (
    input  logic             i_clk,
    input  logic             i_rc,
    input  logic             i_sr,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_d,
    input  logic [TAP_W-1:0] i_tap,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_qt,
    output logic [TAP_W:0]   o_fill,
    output logic             o_full
);
    localparam logic [TAP_W:0] FULL_CNT = DEPTH[TAP_W:0];

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [TAP_W:0]   r_fill;
    logic [WIDTH-1:0] w_qt;

    always_ff @(posedge i_clk or posedge i_rc) begin
        if (i_rc) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
            r_fill <= '0;
        end else if (i_sr) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= SR_VAL;
            r_fill <= '0;
        end else if (i_ce) begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
            r_fill <= (r_fill == FULL_CNT) ? r_fill : r_fill + 1'b1;
        end
    end

    // Tap values beyond the last stage select nothing and read as zero.
    always_comb begin
        w_qt = '0;
        for (int i = 0; i < DEPTH; i++)
            if (i_tap == i[TAP_W-1:0]) w_qt = r_stage[i];
    end

    assign o_q    = r_stage[DEPTH-1];
    assign o_qt   = w_qt;
    assign o_fill = r_fill;
    assign o_full = (r_fill == FULL_CNT);
endmodule

// File: tb/tb_fdcr_delay_line.sv
// tb_fdcr_delay_line: directed scenario tests for fdcr_delay_line (DEPTH=4 main instance,
// DEPTH=3 instance for the out-of-range tap case).
module tb_fdcr_delay_line;
    logic       clk = 1'b0;
    logic       rc, sr, ce;
    logic [3:0] d;
    logic [1:0] tap, tap3;
    logic [3:0] q, qt, q3, qt3;
    logic [2:0] fill, fill3;
    logic       full, full3;
    int         vecs = 0;
    int         errs = 0;

    always #20 clk = ~clk;

    fdcr_delay_line #(.WIDTH(4), .DEPTH(4), .SR_VAL(4'hA), .TAP_W(2)) dut (
        .i_clk(clk), .i_rc(rc), .i_sr(sr), .i_ce(ce), .i_d(d), .i_tap(tap),
        .o_q(q), .o_qt(qt), .o_fill(fill), .o_full(full)
    );

    fdcr_delay_line #(.WIDTH(4), .DEPTH(3), .SR_VAL(4'hA), .TAP_W(2)) dut3 (
        .i_clk(clk), .i_rc(rc), .i_sr(sr), .i_ce(ce), .i_d(d), .i_tap(tap3),
        .o_q(q3), .o_qt(qt3), .o_fill(fill3), .o_full(full3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear;
        rc = 1'b1;
        #3;
        rc = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] ev;
        ev = 4'h0;
        #105;
        vecs++; if (q !== 4'h0) begin errs++; $display("FAIL reset_q got %h exp 0", q); end
        vecs++; if (fill !== 3'd0) begin errs++; $display("FAIL reset_fill got %0d exp 0", fill); end
        vecs++; if (full !== 1'b0) begin errs++; $display("FAIL reset_full got %b exp 0", full); end
        for (int t = 0; t < 4; t++) begin
            tap = 2'(t);
            #1;
            vecs++; if (qt !== ev) begin errs++; $display("FAIL reset_qt tap%0d got %h exp %h", t, qt, ev); end
        end
        rc = 1'b0;
    endtask

    task automatic test_fill;
        logic [3:0] eq;
        logic [2:0] ef;
        ce = 1'b1;
        for (int k = 0; k < 5; k++) begin
            d = 4'(k + 1);
            tick;
            eq = (k >= 3) ? 4'(k - 2) : 4'h0;
            ef = (k >= 3) ? 3'd4 : 3'(k + 1);
            vecs++; if (q !== eq) begin errs++; $display("FAIL fill_q edge%0d got %h exp %h", k, q, eq); end
            vecs++; if (fill !== ef) begin errs++; $display("FAIL fill_cnt edge%0d got %0d exp %0d", k, fill, ef); end
            vecs++; if (full !== (k >= 3)) begin errs++; $display("FAIL fill_full edge%0d got %b exp %b", k, full, k >= 3); end
        end
    endtask

    task automatic test_ce_hold;
        bit         cev [7] = '{1, 1, 0, 0, 1, 1, 1};
        logic [3:0] dv  [7] = '{4'h1, 4'h2, 4'hF, 4'hF, 4'h3, 4'h4, 4'h5};
        logic [3:0] eq  [7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2};
        logic [2:0] ef  [7] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4};
        clear;
        tap = 2'd0;
        for (int k = 0; k < 7; k++) begin
            ce = cev[k];
            d  = dv[k];
            tick;
            vecs++; if (q !== eq[k]) begin errs++; $display("FAIL hold_q edge%0d got %h exp %h", k, q, eq[k]); end
            vecs++; if (fill !== ef[k]) begin errs++; $display("FAIL hold_fill edge%0d got %0d exp %0d", k, fill, ef[k]); end
            if (k == 2 || k == 3) begin
                vecs++; if (qt !== 4'h2) begin errs++; $display("FAIL hold_stage0 edge%0d got %h exp 2", k, qt); end
            end
        end
    endtask

    task automatic test_sync_reset;
        logic [3:0] ev [4] = '{4'h8, 4'h7, 4'h6, 4'h5};
        ce = 1'b1;
        for (int k = 5; k <= 8; k++) begin
            d = 4'(k);
            tick;
        end
        for (int t = 0; t < 4; t++) begin
            tap = 2'(t);
            #1;
            vecs++; if (qt !== ev[t]) begin errs++; $display("FAIL sr_preload tap%0d got %h exp %h", t, qt, ev[t]); end
        end
        ce = 1'b0;
        sr = 1'b1;
        tick;
        sr = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tap = 2'(t);
            #1;
            vecs++; if (qt !== 4'hA) begin errs++; $display("FAIL sr_stage tap%0d got %h exp a", t, qt); end
        end
        vecs++; if (fill !== 3'd0) begin errs++; $display("FAIL sr_fill got %0d exp 0", fill); end
        vecs++; if (full !== 1'b0) begin errs++; $display("FAIL sr_full got %b exp 0", full); end
        #8;
        rc = 1'b1;
        #2;
        vecs++; if (q !== 4'h0) begin errs++; $display("FAIL rc_async_q got %h exp 0", q); end
        tap = 2'd1;
        #1;
        vecs++; if (qt !== 4'h0) begin errs++; $display("FAIL rc_async_qt got %h exp 0", qt); end
        rc = 1'b0;
    endtask

    task automatic test_priority;
        sr = 1'b1;
        ce = 1'b1;
        d  = 4'h7;
        tick;
        for (int t = 0; t < 4; t++) begin
            tap = 2'(t);
            #1;
            vecs++; if (qt !== 4'hA) begin errs++; $display("FAIL prio_sr_ce tap%0d got %h exp a", t, qt); end
        end
        vecs++; if (fill !== 3'd0) begin errs++; $display("FAIL prio_sr_ce_fill got %0d exp 0", fill); end
        rc = 1'b1;
        tick;
        for (int t = 0; t < 4; t++) begin
            tap = 2'(t);
            #1;
            vecs++; if (qt !== 4'h0) begin errs++; $display("FAIL prio_rc_sr tap%0d got %h exp 0", t, qt); end
        end
        rc = 1'b0;
        sr = 1'b0;
        ce = 1'b0;
        tick;
        vecs++; if (fill !== 3'd0) begin errs++; $display("FAIL rc_release_fill got %0d exp 0", fill); end
        vecs++; if (q !== 4'h0) begin errs++; $display("FAIL rc_release_q got %h exp 0", q); end
    endtask

    task automatic test_tap;
        logic [3:0] ev [4] = '{4'h9, 4'h8, 4'h7, 4'h6};
        clear;
        ce = 1'b1;
        for (int k = 6; k <= 9; k++) begin
            d = 4'(k);
            tick;
        end
        ce = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tap = 2'(t);
            #1;
            vecs++; if (qt !== ev[t]) begin errs++; $display("FAIL tap_sweep tap%0d got %h exp %h", t, qt, ev[t]); end
        end
        tap3 = 2'd2;
        #1;
        vecs++; if (qt3 !== 4'h7) begin errs++; $display("FAIL tap_d3_last got %h exp 7", qt3); end
        tap3 = 2'd3;
        #1;
        vecs++; if (qt3 !== 4'h0) begin errs++; $display("FAIL tap_d3_oob got %h exp 0", qt3); end
        vecs++; if (fill3 !== 3'd3 || full3 !== 1'b1) begin errs++; $display("FAIL d3_fill got %0d/%b exp 3/1", fill3, full3); end
    endtask

    task automatic test_saturation;
        ce = 1'b1;
        for (int k = 0; k < 20; k++) begin
            d = 4'(k);
            tick;
            vecs++; if (fill !== 3'd4) begin errs++; $display("FAIL sat_fill edge%0d got %0d exp 4", k, fill); end
            vecs++; if (full !== 1'b1) begin errs++; $display("FAIL sat_full edge%0d got %b exp 1", k, full); end
            if (k >= 3) begin
                vecs++; if (q !== 4'(k - 3)) begin errs++; $display("FAIL sat_q edge%0d got %h exp %h", k, q, 4'(k - 3)); end
            end
        end
        ce = 1'b0;
    endtask

    initial begin
        rc = 1'b1; sr = 1'b0; ce = 1'b0; d = 4'h0; tap = 2'd0; tap3 = 2'd0;
        test_reset;
        test_fill;
        test_ce_hold;
        test_sync_reset;
        test_priority;
        test_tap;
        test_saturation;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
